seq_runner: RTL and testbench

Parametrised single-shot sequencer generalising the start/running/done stall-or-sync controller. A start pulse latches a mode, a cycle/event count and a sync-channel select. The block then stalls, waits for a selected external sync, counts sync edges, or stalls then waits, and finishes with a one-cycle done pulse. It sits between control registers and the datapath blocks it gates.

---
 rtl/seq_runner.sv | 230 +++++++++++++++++++++++
 tb/tb_seq_runner.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_runner.sv
// seq_runner: single-shot sequencer for gating a datapath block.
//
// A start pulse latches mode, count, sync_sel and timeout. The block then
// stalls for count+1 cycles, waits for a selected external sync level,
// counts rising edges of a selected sync line, or stalls and then waits for
// the sync level. Each sequence ends with a one-cycle done pulse, or with a
// one-cycle aborted pulse when abort is asserted.
//
// Optional feature: define SEQ_RUNNER_TIMEOUT_EN to enable the sync-wait
// timeout. When it is enabled, a wait that expires ends with done and
// error=1. When it is not defined, the timeout port is ignored, error is
// held at 0, and sync waits have no limit.
//
// Ports:
//   clk        clock; all logic acts on the rising edge
//   reset_n    asynchronous active-low reset
//   ext_sync   external sync lines [NSYNC], synchronous to clk
//   mode       0 stall, 1 sync level, 2 sync edge count, 3 stall then sync
//   count      stall length / number of edges to count
//   sync_sel   selects the ext_sync bit; values >= NSYNC select bit 0
//   timeout    sync-wait limit in cycles, 0 = no limit
//   start      launch pulse; restarts from any state
//   abort      cancels a running sequence
//   running    high while in STALL, SYNC or EDGE
//   done       one-cycle completion pulse
//   error      qualifies done: 1 = the sequence ended by timeout
//   aborted    one-cycle pulse after an abort
module seq_runner #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned NSYNC = 4,
    parameter int unsigned SEL_W = 2,
    parameter int unsigned TMO_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NSYNC-1:0] ext_sync,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic [SEL_W-1:0] sync_sel,
    input  logic [TMO_W-1:0] timeout,
    input  logic             start,
    input  logic             abort,
    output logic             running,
    output logic             done,
    output logic             error,
    output logic             aborted
);

    typedef enum logic [2:0] {
        IDLE,
        STALL,
        SYNC,
        EDGE,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_STALL      = 2'd0,
        MODE_SYNC       = 2'd1,
        MODE_EDGE       = 2'd2,
        MODE_STALL_SYNC = 2'd3
    } mode_t;

    state_t             state_q, state_n;
    mode_t              mode_q, mode_n;
    logic [SEL_W-1:0]   sel_q, sel_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [NSYNC-1:0]   prev_q;
    logic               abt_q, abt_n;

    logic               sync_now;
    logic               sync_prev;
    logic               rise;
    logic               timed_out;

`ifdef SEQ_RUNNER_TIMEOUT_EN
    logic [TMO_W-1:0]   tlim_q, tlim_n;
    logic [TMO_W-1:0]   tmo_q, tmo_n;
    logic [TMO_W-1:0]   tmo_sat;
    logic               err_q, err_n;
`else
    logic               unused_timeout;
    assign unused_timeout = ^timeout;
`endif

    // Select the sync line and its history bit; out-of-range selects fall
    // back to bit 0.
    always_comb begin
        sync_now  = ext_sync[0];
        sync_prev = prev_q[0];
        for (int unsigned i = 0; i < NSYNC; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sync_now  = ext_sync[i];
                sync_prev = prev_q[i];
            end
        end
    end

    assign rise = sync_now & ~sync_prev;

`ifdef SEQ_RUNNER_TIMEOUT_EN
    assign tmo_sat   = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
    // Fires on the last allowed wait cycle; the sync/edge checks ahead of it
    // give a qualifying event on that same cycle priority.
    assign timed_out = (tlim_q != '0) && (tmo_q == tlim_q - TMO_W'(1));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_n = state_q;
        mode_n  = mode_q;
        sel_n   = sel_q;
        cnt_n   = cnt_q;
        abt_n   = 1'b0;
`ifdef SEQ_RUNNER_TIMEOUT_EN
        tlim_n  = tlim_q;
        tmo_n   = tmo_q;
        err_n   = err_q;
`endif
        if (start) begin
            // start takes priority over abort and over any completion.
            mode_n = mode_t'(mode);
            sel_n  = sync_sel;
            cnt_n  = count;
`ifdef SEQ_RUNNER_TIMEOUT_EN
            tlim_n = timeout;
            tmo_n  = '0;
            err_n  = 1'b0;
`endif
            case (mode_t'(mode))
                MODE_SYNC: state_n = SYNC;
                MODE_EDGE: state_n = EDGE;
                default:   state_n = STALL;
            endcase
        end else if (abort && running) begin
            state_n = IDLE;
            abt_n   = 1'b1;
        end else begin
            case (state_q)
                STALL: begin
                    if (cnt_q == '0) begin
                        if (mode_q == MODE_STALL_SYNC) begin
                            state_n = SYNC;
`ifdef SEQ_RUNNER_TIMEOUT_EN
                            tmo_n   = '0;
`endif
                        end else begin
                            state_n = DONE;
                        end
                    end else begin
                        cnt_n = cnt_q - CNT_W'(1);
                    end
                end
                SYNC: begin
                    if (sync_now) begin
                        state_n = DONE;
                    end else if (timed_out) begin
                        state_n = DONE;
`ifdef SEQ_RUNNER_TIMEOUT_EN
                        err_n   = 1'b1;
`endif
                    end else begin
`ifdef SEQ_RUNNER_TIMEOUT_EN
                        tmo_n = tmo_sat;
`endif
                    end
                end
                EDGE: begin
                    // count 0 and count 1 both finish on the first edge.
                    if (rise && (cnt_q <= CNT_W'(1))) begin
                        state_n = DONE;
                    end else if (timed_out) begin
                        state_n = DONE;
`ifdef SEQ_RUNNER_TIMEOUT_EN
                        err_n   = 1'b1;
`endif
                    end else begin
                        if (rise) begin
                            cnt_n = cnt_q - CNT_W'(1);
                        end
`ifdef SEQ_RUNNER_TIMEOUT_EN
                        tmo_n = tmo_sat;
`endif
                    end
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_STALL;
            sel_q   <= '0;
            cnt_q   <= '0;
            prev_q  <= '0;
            abt_q   <= 1'b0;
`ifdef SEQ_RUNNER_TIMEOUT_EN
            tlim_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            mode_q  <= mode_n;
            sel_q   <= sel_n;
            cnt_q   <= cnt_n;
            prev_q  <= ext_sync;
            abt_q   <= abt_n;
`ifdef SEQ_RUNNER_TIMEOUT_EN
            tlim_q  <= tlim_n;
            tmo_q   <= tmo_n;
            err_q   <= err_n;
`endif
        end
    end

    assign running = (state_q == STALL) || (state_q == SYNC) || (state_q == EDGE);
    assign done    = (state_q == DONE);
    assign aborted = abt_q;
`ifdef SEQ_RUNNER_TIMEOUT_EN
    assign error   = err_q;
`else
    assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_runner.sv
// tb_seq_runner: scoreboard bench for seq_runner. Stimulus pushes the
// expected completion event (done or aborted, cycle, running length, error)
// into a queue; the monitor pops and compares whenever the DUT pulses done
// or aborted. Instantiated with NSYNC=3 so sync_sel=3 exercises the
// out-of-range fallback to bit 0.
module tb_seq_runner;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned NSYNC = 3;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned TMO_W = 16;

    logic             clk;
    logic             reset_n;
    logic [NSYNC-1:0] ext_sync;
    logic [1:0]       mode;
    logic [CNT_W-1:0] count;
    logic [SEL_W-1:0] sync_sel;
    logic [TMO_W-1:0] timeout;
    logic             start;
    logic             abort;
    logic             running;
    logic             done;
    logic             error;
    logic             aborted;

    seq_runner #(
        .CNT_W(CNT_W),
        .NSYNC(NSYNC),
        .SEL_W(SEL_W),
        .TMO_W(TMO_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ext_sync(ext_sync),
        .mode    (mode),
        .count   (count),
        .sync_sel(sync_sel),
        .timeout (timeout),
        .start   (start),
        .abort   (abort),
        .running (running),
        .done    (done),
        .error   (error),
        .aborted (aborted)
    );

    typedef struct {
        bit          is_abort;
        bit          err;
        int unsigned at;
        int unsigned run;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    int unsigned run_len = 0;
    int unsigned k;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) tick();
    endtask

    task automatic push_exp(input bit ab, input bit er, input int unsigned at, input int unsigned run);
        exp_t e;
        e.is_abort = ab;
        e.err      = er;
        e.at       = at;
        e.run      = run;
        sb.push_back(e);
    endtask

    task automatic do_start(input logic [1:0] m, input logic [CNT_W-1:0] c,
                            input logic [SEL_W-1:0] s, input logic [TMO_W-1:0] t,
                            output int unsigned kk);
        mode     = m;
        count    = c;
        sync_sel = s;
        timeout  = t;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        kk       = cyc;
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            run_len = 0;
        end else begin
            chk("run_done_excl", 32'(running & done), 32'd0);
            chk("done_abort_excl", 32'(done & aborted), 32'd0);
            if (done || aborted) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got done=%0d aborted=%0d at cycle %0d, expected none",
                             done, aborted, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("event_kind_aborted", 32'(aborted), 32'(mon_e.is_abort));
                    chk("event_cycle", cyc, mon_e.at);
                    chk("running_len", run_len, mon_e.run);
                    if (!mon_e.is_abort) chk("error_flag", 32'(error), 32'(mon_e.err));
                end
            end
            if (running) run_len++;
            else run_len = 0;
        end
    end

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        ext_sync = '0;
        mode     = 2'd0;
        count    = '0;
        sync_sel = '0;
        timeout  = '0;
        #2;
        chk("reset_running", 32'(running), 32'd0);
        chk("reset_done",    32'(done),    32'd0);
        chk("reset_error",   32'(error),   32'd0);
        chk("reset_aborted", 32'(aborted), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // mode 0, count 3: running 4 cycles, done after edge k+4
        do_start(2'd0, 8'd3, 2'd0, 16'd0, k);
        push_exp(1'b0, 1'b0, k + 4, 4);
        idle(6);

        // mode 0, count 0: running 1 cycle
        do_start(2'd0, 8'd0, 2'd0, 16'd0, k);
        push_exp(1'b0, 1'b0, k + 1, 1);
        idle(4);

        // mode 1: sync present only on the start edge is ignored
        ext_sync[0] = 1'b1;
        do_start(2'd1, 8'd0, 2'd0, 16'd0, k);
        push_exp(1'b0, 1'b0, k + 3, 3);
        ext_sync[0] = 1'b0;
        idle(2);
        ext_sync[0] = 1'b1;
        tick();
        ext_sync[0] = 1'b0;
        idle(4);

        // mode 2, count 3, sel 2: long high level is one edge, then two pulses
        do_start(2'd2, 8'd3, 2'd2, 16'd0, k);
        push_exp(1'b0, 1'b0, k + 14, 14);
        ext_sync[2] = 1'b1;
        idle(10);
        ext_sync[2] = 1'b0;
        tick();
        repeat (3) begin
            ext_sync[2] = 1'b1;
            tick();
            ext_sync[2] = 1'b0;
            tick();
        end
        idle(3);

        // mode 2, count 0, sel 3 (out of range -> bit 0); edge on bit 2 ignored
        do_start(2'd2, 8'd0, 2'd3, 16'd0, k);
        push_exp(1'b0, 1'b0, k + 3, 3);
        ext_sync[2] = 1'b1;
        tick();
        ext_sync = '0;
        tick();
        ext_sync[0] = 1'b1;
        tick();
        ext_sync = '0;
        idle(4);

        // mode 3, count 2, sel 1: sync high during STALL not seen
        ext_sync[1] = 1'b1;
        do_start(2'd3, 8'd2, 2'd1, 16'd0, k);
        push_exp(1'b0, 1'b0, k + 8, 8);
        idle(3);
        ext_sync[1] = 1'b0;
        idle(4);
        ext_sync[1] = 1'b1;
        tick();
        ext_sync[1] = 1'b0;
        idle(4);

        // mode 1 abort after 4 running cycles
        do_start(2'd1, 8'd0, 2'd0, 16'd0, k);
        push_exp(1'b1, 1'b0, k + 4, 4);
        idle(3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        idle(3);

        // abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        idle(2);

        // start with abort in the same cycle; input changes while running ignored
        abort = 1'b1;
        do_start(2'd0, 8'd2, 2'd0, 16'd0, k);
        abort = 1'b0;
        mode  = 2'd1;
        count = 8'd9;
        push_exp(1'b0, 1'b0, k + 3, 3);
        idle(6);

`ifdef SEQ_RUNNER_TIMEOUT_EN
        // timeout 5, no sync: done with error after 5 SYNC cycles
        do_start(2'd1, 8'd0, 2'd0, 16'd5, k);
        timeout = 16'd0;
        push_exp(1'b0, 1'b1, k + 5, 5);
        idle(8);

        // sync on the 5th cycle wins over the timeout
        do_start(2'd1, 8'd0, 2'd0, 16'd5, k);
        push_exp(1'b0, 1'b0, k + 5, 5);
        idle(4);
        ext_sync[0] = 1'b1;
        tick();
        ext_sync[0] = 1'b0;
        idle(4);
`else
        // without the timeout feature the wait never ends on its own
        do_start(2'd1, 8'd0, 2'd0, 16'd5, k);
        push_exp(1'b1, 1'b0, k + 21, 21);
        idle(20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        idle(3);
`endif

        // reset mid-STALL: outputs clear immediately, no done afterwards
        do_start(2'd0, 8'd5, 2'd0, 16'd0, k);
        idle(3);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_running", 32'(running), 32'd0);
        chk("midreset_done",    32'(done),    32'd0);
        chk("midreset_error",   32'(error),   32'd0);
        chk("midreset_aborted", 32'(aborted), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(10);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
